// File: rtl/shifter.sv
// 32-bit barrel shifter with a registered result.
// Left shifts reuse the right-shift network through bit reversal.
module shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic        l_or_r,
  input  logic        a_or_h,
  output logic [31:0] result
);

  logic [4:0]  w_sh;
  logic        w_fill;
  logic        w_unused_hi;
  logic [31:0] w_in;
  logic [31:0] w_s0;
  logic [31:0] w_s1;
  logic [31:0] w_s2;
  logic [31:0] w_s3;
  logic [31:0] w_s4;
  logic [31:0] w_out;
  logic [31:0] r_result;

  assign w_sh        = datab[4:0];
  assign w_unused_hi = ^datab[31:5];
  assign w_fill      = a_or_h & ~l_or_r & dataa[31];

  always_comb begin
    w_in = dataa;
    if (l_or_r) begin
      for (int i = 0; i < 32; i++) begin
        w_in[i] = dataa[31-i];
      end
    end
  end

  assign w_s0 = w_sh[0] ?
    {w_fill, w_in[31:1]} : w_in;
  assign w_s1 = w_sh[1] ?
    {{2{w_fill}}, w_s0[31:2]} : w_s0;
  assign w_s2 = w_sh[2] ?
    {{4{w_fill}}, w_s1[31:4]} : w_s1;
  assign w_s3 = w_sh[3] ?
    {{8{w_fill}}, w_s2[31:8]} : w_s2;
  assign w_s4 = w_sh[4] ?
    {{16{w_fill}}, w_s3[31:16]} : w_s3;

  always_comb begin
    w_out = w_s4;
    if (l_or_r) begin
      for (int i = 0; i < 32; i++) begin
        w_out[i] = w_s4[31-i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= 32'h0;
    end else begin
      r_result <= w_out;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_shifter.sv
// Bench for shifter: directed literal vectors plus
// random vectors against an arithmetic reference model.
module tb_shifter;

  logic        clk;
  logic        rst;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        l_or_r;
  logic        a_or_h;
  logic [31:0] result;

  int n_chk;
  int n_fail;

  logic [31:0] exp_q;
  logic        vld;

  shifter dut (
    .clk    (clk),
    .rst    (rst),
    .dataa  (dataa),
    .datab  (datab),
    .l_or_r (l_or_r),
    .a_or_h (a_or_h),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        l,
    input logic        h
  );
    int unsigned sh;
    sh = b % 32;
    if (l) return a << sh;
    if (h) return $signed(a) >>> sh;
    return a >> sh;
  endfunction

  // Reference: what the register must hold after each edge.
  initial vld = 1'b0;
  always @(posedge clk) begin
    if (rst) exp_q <= 32'h0;
    else exp_q <= model(dataa, datab, l_or_r, a_or_h);
    vld <= 1'b1;
  end

  always @(negedge clk) begin
    if (vld) begin
      n_chk++;
      if (result !== exp_q) begin
        n_fail++;
        $display("FAIL cycle_cmp: got %h expected %h",
                 result, exp_q);
      end
    end
  end

  task automatic drive(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        l,
    input logic        h,
    input logic        r
  );
    @(negedge clk);
    dataa  = a;
    datab  = b;
    l_or_r = l;
    a_or_h = h;
    rst    = r;
  endtask

  task automatic lit(
    input string       name,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        l,
    input logic        h,
    input logic        r,
    input logic [31:0] e
  );
    drive(a, b, l, h, r);
    if (!r) begin
      n_chk++;
      if (model(a, b, l, h) !== e) begin
        n_fail++;
        $display("FAIL %s_model: got %h expected %h",
                 name, model(a, b, l, h), e);
      end
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (result !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, result, e);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    dataa  = 32'h0;
    datab  = 32'h0;
    l_or_r = 1'b0;
    a_or_h = 1'b0;
    rst    = 1'b1;

    lit("reset", 32'hFFFF_FFF8, 32'd2, 0, 0, 1,
        32'h0);
    lit("srl2", 32'hFFFF_FFF8, 32'd2, 0, 0, 0,
        32'h3FFF_FFFE);
    lit("sll2", 32'hFFFF_FFF8, 32'd2, 1, 0, 0,
        32'hFFFF_FFE0);
    lit("sra2", 32'hFFFF_FFF8, 32'd2, 0, 1, 0,
        32'hFFFF_FFFE);
    lit("sla2", 32'hFFFF_FFF8, 32'd2, 1, 1, 0,
        32'hFFFF_FFE0);
    lit("srl31", 32'h8000_0001, 32'd31, 0, 0, 0,
        32'h0000_0001);
    lit("sra31", 32'h8000_0001, 32'd31, 0, 1, 0,
        32'hFFFF_FFFF);
    lit("sll31", 32'h8000_0001, 32'd31, 1, 0, 0,
        32'h8000_0000);
    for (int m = 0; m < 4; m++) begin
      lit("zero_sh", 32'hA5C3_0F96, 32'h0,
          m[1], m[0], 0, 32'hA5C3_0F96);
    end
    lit("mask_hi", 32'h0000_0004, 32'h0000_0021,
        1, 0, 0, 32'h0000_0008);
    lit("mask_hi2", 32'h0000_0004, 32'hFFFF_FFE0,
        1, 0, 0, 32'h0000_0004);
    lit("sra_pos", 32'h4000_0000, 32'd4, 0, 1, 0,
        32'h0400_0000);
    lit("rst_mid", 32'hFFFF_FFFF, 32'd0, 0, 0, 1,
        32'h0);

    for (int i = 0; i < 10000; i++) begin
      drive($urandom, $urandom, 1'($urandom),
            1'($urandom), ($urandom_range(0, 49) == 0));
    end
    drive(32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shifter.md
# shifter

32-bit barrel shifter with a registered result for the EXP11 datapath. It shifts `dataa` by the amount in the low five bits of `datab`. The direction is left or right. Right shifts are logical or arithmetic. The result is captured on the rising clock edge. It sits beside the ALU and feeds shift instructions (SLL/SRL/SRA and variable forms) into the result mux.

## Interface
- No parameters; width fixed at 32, shift-amount field fixed at 5 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `dataa` input 32: operand to be shifted.
- `datab` input 32: shift amount; only `datab[4:0]` is used, `datab[31:5]` ignored.
- `l_or_r` input 1: direction; 1 = shift left, 0 = shift right.
- `a_or_h` input 1: kind; 1 = arithmetic, 0 = logical.
- `result` output 32: registered shift result.

## Operation
- `sh = datab[4:0]`, range 0..31; no saturation, no error for larger `datab`.
- `l_or_r=0, a_or_h=0`: logical right; vacated MSBs filled with 0.
- `l_or_r=0, a_or_h=1`: arithmetic right; vacated MSBs filled with `dataa[31]`.
- `l_or_r=1`, either `a_or_h`: left shift; vacated LSBs filled with 0. Arithmetic left equals logical left, with no overflow detection and no sign preservation.
- `sh=0`: result equals `dataa` for every mode.
- Implementation: five-stage combinational barrel network (shift by 1, 2, 4, 8, 16 gated by `sh[0..4]`), followed by one 32-bit output register.
  - Left shifts may be built by bit-reversing in and out of a right-shift network.
  - Fill bit for the right network = `a_or_h & ~l_or_r & dataa[31]`.
- No internal state besides the output register; each result depends only on the inputs sampled at one edge.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge N appear on `result` after edge N and hold until edge N+1.
- Throughput: one operation per cycle; no handshake, no stall; a new operation is accepted every edge.
- Reset: `rst=1` at a rising edge forces `result` to 32'h0000_0000, overriding the inputs sampled at that edge.
  - The first post-reset result appears after the first edge with `rst=0`.
- Before the first clock edge, `result` is undefined; reset is required.
- Input changes between edges have no effect on `result`, which holds the value from the last edge.
- The combinational path (five mux levels) must close at the system clock.

## Test plan
- Reset: assert `rst` one cycle with `dataa=32'hFFFF_FFF8` -> `result=32'h0`. After release, the next edge yields the shifted value.
- `dataa=-8 (32'hFFFF_FFF8)`, `datab=2`, cycle through four modes, one per cycle:
  - `l_or_r=0, a_or_h=0` -> `32'h3FFF_FFFE`
  - `l_or_r=1, a_or_h=0` -> `32'hFFFF_FFE0`
  - `l_or_r=0, a_or_h=1` -> `32'hFFFF_FFFE`
  - `l_or_r=1, a_or_h=1` -> `32'hFFFF_FFE0`
  - Each result must appear exactly one cycle after its inputs.
- Extreme shifts on `dataa=32'h8000_0001`:
  - `datab=31`, logical right -> `32'h0000_0001`
  - `datab=31`, arithmetic right -> `32'hFFFF_FFFF`
  - `datab=31`, left -> `32'h8000_0000`
- Zero and upper-bit masking:
  - `datab=0` -> `result=dataa` in all modes.
  - `datab=32'h0000_0021` (low bits =1), `dataa=32'h0000_0004`, left -> `32'h0000_0008`.
- Positive arithmetic right: `dataa=32'h4000_0000`, `datab=4`, arithmetic right -> `32'h0400_0000` (zero fill).
- Randomized: 10k random operand/amount/mode vectors compared against a reference model with one-cycle delay, with random single-cycle `rst` pulses that must zero `result` on the following edge.
